// File: rtl/memory_bank_pkg.sv
// Shared definitions for the banked dual-request memory: bank geometry helpers
// and the init/run sequencer encoding.
package memory_bank_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int bank_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int bank_depth(input int addr_w, input int num_banks);
    return (1 << addr_w) / num_banks;
  endfunction

endpackage

// File: rtl/memory_bank_sp.sv
// One synchronous single-port bank: registered read, array has no reset.
module memory_bank_sp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first: a write cycle returns the previous word, which nobody consumes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_bank_dp.sv
// Banked memory with independent write and read request ports, write-first
// same-bank arbitration, a read ready handshake and a zero-fill init sequencer.
module memory_bank_dp
  import memory_bank_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int NUM_BANKS = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              CEB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              init_done,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int BANK_BITS  = bank_bits(NUM_BANKS);
  localparam int OFF_W      = ADDR_W - BANK_BITS;
  localparam int BANK_DEPTH = bank_depth(ADDR_W, NUM_BANKS);

  state_t               state_reg;
  logic [OFF_W-1:0]     ptr_reg;
  logic                 rd_pend_reg;
  logic [BANK_BITS-1:0] rd_bank_reg;
  logic [DATA_W-1:0]    dout_reg;
  logic                 rd_valid_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic                 in_init;
  logic                 in_run;
  logic [BANK_BITS-1:0] wr_bank;
  logic [BANK_BITS-1:0] rd_bank;
  logic [OFF_W-1:0]     wr_off;
  logic [OFF_W-1:0]     rd_off;
  logic                 same_bank_wr;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 rd_blocked;

  logic [NUM_BANKS-1:0] bank_en;
  logic [NUM_BANKS-1:0] bank_we;
  logic [OFF_W-1:0]     bank_addr  [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  assign in_init = (state_reg == ST_INIT);
  assign in_run  = (state_reg == ST_RUN);

  assign wr_bank = wr_addr[ADDR_W-1 -: BANK_BITS];
  assign rd_bank = rd_addr[ADDR_W-1 -: BANK_BITS];
  assign wr_off  = wr_addr[OFF_W-1:0];
  assign rd_off  = rd_addr[OFF_W-1:0];

  // A write to the read's bank occupies that single port, so the read waits.
  assign same_bank_wr = wr_en && (wr_bank == rd_bank);
  assign rd_ready     = in_run && !CEB && !same_bank_wr;
  assign wr_acc       = in_run && !CEB && wr_en;
  assign rd_acc       = rd_en && rd_ready;
  assign rd_blocked   = rd_en && in_run && !CEB && !rd_ready;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic wr_hit;
      logic rd_hit;

      assign wr_hit = wr_acc && (wr_bank == BANK_BITS'(gi));
      assign rd_hit = rd_acc && (rd_bank == BANK_BITS'(gi));

      assign bank_en[gi]    = in_init || wr_hit || rd_hit;
      assign bank_we[gi]    = in_init || wr_hit;
      assign bank_addr[gi]  = in_init ? ptr_reg : (wr_hit ? wr_off : rd_off);
      assign bank_wdata[gi] = in_init ? '0 : din;

      memory_bank_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (OFF_W)
      ) u_bank (
        .clk   (clk),
        .en    (bank_en[gi]),
        .we    (bank_we[gi]),
        .addr  (bank_addr[gi]),
        .wdata (bank_wdata[gi]),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else if (in_init) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (ptr_reg == OFF_W'(BANK_DEPTH - 1)) begin
        state_reg <= ST_RUN;
      end
    end
  end

  // Bank data lands one edge after accept; the output register adds the second.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      rd_pend_reg  <= 1'b0;
      rd_bank_reg  <= '0;
      dout_reg     <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_pend_reg  <= rd_acc;
      rd_valid_reg <= rd_pend_reg;
      if (rd_acc) begin
        rd_bank_reg <= rd_bank;
      end
      if (rd_pend_reg) begin
        dout_reg <= bank_rdata[rd_bank_reg];
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt_reg <= '0;
    end else if (rd_blocked && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign dout         = dout_reg;
  assign rd_valid     = rd_valid_reg;
  assign init_done    = in_run;
  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_memory_bank_dp.sv
// Randomized and directed bench for memory_bank_dp against a flat-array
// reference model of the banked memory's observable behaviour.
module tb_memory_bank_dp;

  logic        clk;
  logic        RESET;
  logic        CEB;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  din;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        rd_ready;
  logic [7:0]  dout;
  logic        rd_valid;
  logic        init_done;
  logic [15:0] conflict_cnt;

  memory_bank_dp #(
    .DATA_W    (8),
    .ADDR_W    (12),
    .NUM_BANKS (4),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .CEB          (CEB),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .din          (din),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_ready     (rd_ready),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .init_done    (init_done),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // Reference model: flat memory plus the observable read pipeline.
  logic [7:0]  mem_m [4096];
  bit          run_m;
  int          cyc_m;
  bit          p1_v;
  logic [7:0]  p1_d;
  bit          exp_valid;
  logic [7:0]  exp_dout;
  logic [15:0] exp_cnt;
  bit          last_blocked;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
    run_m = 0; cyc_m = 0; p1_v = 0; p1_d = 8'h00;
    exp_valid = 0; exp_dout = 8'h00; exp_cnt = 16'h0; last_blocked = 0;
  endtask

  // One clock: drive, check at the falling edge, advance the model across the rising edge.
  task automatic cyc(input logic we, input logic [11:0] wa, input logic [7:0] d,
                     input logic re, input logic [11:0] ra, input logic ceb);
    bit exp_ready, wr_acc, rd_acc;
    wr_en = we; wr_addr = wa; din = d; rd_en = re; rd_addr = ra; CEB = ceb;
    @(negedge clk);
    exp_ready = run_m && !ceb && !(we && (wa[11:10] == ra[11:10]));
    check_eq("rd_ready", rd_ready, exp_ready);
    check_eq("rd_valid", rd_valid, exp_valid);
    check_eq("dout", dout, exp_dout);
    check_eq("conflict_cnt", conflict_cnt, exp_cnt);
    check_eq("init_done", init_done, run_m);
    wr_acc = run_m && !ceb && we;
    rd_acc = re && exp_ready;
    exp_valid = p1_v;
    if (p1_v) exp_dout = p1_d;
    p1_v = rd_acc;
    p1_d = mem_m[ra];
    if (wr_acc) begin
      mem_m[wa] = d;
      $display("[TB] wr %03h <= %02h", wa, d);
    end
    if (rd_acc) $display("[TB] rd %03h -> expect %02h", ra, mem_m[ra]);
    last_blocked = re && !rd_acc;
    if (re && run_m && !ceb && !exp_ready && exp_cnt != 16'hFFFF) exp_cnt++;
    if (!run_m) begin
      cyc_m++;
      if (cyc_m == 1024) run_m = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic read_expect(input string tag, input logic [11:0] a, input logic [7:0] v);
    cyc(1'b0, 12'h000, 8'h00, 1'b1, a, 1'b0);
    idle();
    idle();
    check_eq(tag, dout, v);
  endtask

  function automatic logic [11:0] pick_addr();
    return 12'(($urandom_range(0, 15) * 263) % 4096);
  endfunction

  task automatic run_init();
    for (int i = 0; i < 1024; i++)
      cyc(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic        re_h;
    logic [11:0] ra_h;
    logic [15:0] cnt0;
    tests_run = 0; tests_failed = 0;
    RESET = 1'b0; CEB = 1'b0; wr_en = 1'b0; wr_addr = '0; din = '0; rd_en = 1'b0; rd_addr = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_cnt", conflict_cnt, 16'h0);
    check_eq("rst_rd_ready", rd_ready, 1'b0);
    RESET = 1'b1;

    run_init();
    read_expect("init_zero_dac", 12'hDAC, 8'h00);

    cyc(1'b1, 12'h1F4, 8'h0A, 1'b0, 12'h000, 1'b0);
    cyc(1'b1, 12'h4B0, 8'h0B, 1'b0, 12'h000, 1'b0);
    cyc(1'b1, 12'hA8C, 8'h0C, 1'b0, 12'h000, 1'b0);
    cyc(1'b1, 12'hDAC, 8'h0D, 1'b0, 12'h000, 1'b0);
    read_expect("rd_1f4", 12'h1F4, 8'h0A);
    read_expect("rd_4b0", 12'h4B0, 8'h0B);
    read_expect("rd_a8c", 12'hA8C, 8'h0C);
    read_expect("rd_dac", 12'hDAC, 8'h0D);

    cnt0 = exp_cnt;
    cyc(1'b1, 12'h4B0, 8'h0E, 1'b1, 12'hA8C, 1'b0);
    idle();
    idle();
    check_eq("par_rd_a8c", dout, 8'h0C);
    check_eq("par_cnt", conflict_cnt, cnt0);
    read_expect("rd_4b0_new", 12'h4B0, 8'h0E);

    cnt0 = exp_cnt;
    repeat (3) cyc(1'b1, 12'hC80, 8'h88, 1'b1, 12'hD48, 1'b0);
    check_eq("conflict_3", conflict_cnt, cnt0 + 16'd3);
    read_expect("rd_d48_old", 12'hD48, 8'h00);
    cyc(1'b1, 12'hC80, 8'h88, 1'b1, 12'hC80, 1'b0);
    read_expect("rd_c80_new", 12'hC80, 8'h88);

    cnt0 = exp_cnt;
    cyc(1'b1, 12'h12C, 8'h55, 1'b1, 12'h12C, 1'b1);
    idle();
    idle();
    check_eq("ceb_no_valid", rd_valid, 1'b0);
    check_eq("ceb_cnt", conflict_cnt, cnt0);
    read_expect("ceb_no_write", 12'h12C, 8'h00);

    re_h = 1'b0; ra_h = '0;
    for (int i = 0; i < 600; i++) begin
      if (!last_blocked) begin
        re_h = 1'($urandom_range(0, 1));
        ra_h = pick_addr();
      end
      cyc(1'($urandom_range(0, 2) != 0), pick_addr(), 8'($urandom_range(0, 255)),
          re_h, ra_h, 1'($urandom_range(0, 7) == 0));
    end

    wr_en = 1'b1; wr_addr = 12'h1F4; din = 8'h77; rd_en = 1'b1; rd_addr = 12'hA8C; CEB = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    check_eq("arst_dout", dout, 8'h00);
    check_eq("arst_rd_valid", rd_valid, 1'b0);
    check_eq("arst_init_done", init_done, 1'b0);
    check_eq("arst_cnt", conflict_cnt, 16'h0);
    reset_model();
    @(posedge clk);
    #1;
    RESET = 1'b1;
    run_init();
    read_expect("reinit_1f4", 12'h1F4, 8'h00);
    read_expect("reinit_4b0", 12'h4B0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_bank_dp.md
Name: memory_bank_dp

Overview:
- Parametrised successor to the 4 KB four-bank memory: NUM_BANKS single-ported banks, bank selected by the upper address bits.
- Separate write and read request ports, so a write and a read to different banks complete in the same cycle.
- Same-bank collisions are arbitrated write-first, with a ready handshake on the read port.
- After reset, an init sequencer zero-fills every bank before accepting traffic.
- Sits between the bus-side controller and the storage array.

Parameters:
- DATA_W, 8: data width in bits.
- ADDR_W, 12: word-address width; total depth 2^ADDR_W.
- NUM_BANKS, 4: bank count. Power of two, at least 2; bank index = addr[ADDR_W-1 -: log2(NUM_BANKS)].
- CNT_W, 16: width of the conflict counter.

Ports:
- clk, in, 1: clock, rising edge.
- RESET, in, 1: asynchronous active-low reset.
- CEB, in, 1: chip enable, active-low. High blocks all accepts on both ports.
- wr_en, in, 1: write request.
- wr_addr, in, ADDR_W: write address.
- din, in, DATA_W: write data.
- rd_en, in, 1: read request.
- rd_addr, in, ADDR_W: read address.
- rd_ready, out, 1: read accepted this cycle when rd_en is also high.
- dout, out, DATA_W: read data.
- rd_valid, out, 1: dout valid, one-cycle pulse per accepted read.
- init_done, out, 1: high once zero-fill completes.
- conflict_cnt, out, CNT_W: saturating count of cycles with a blocked read.

Behaviour:
- Reset (RESET low, asynchronous):
  - FSM goes to INIT with init pointer = 0.
  - dout=0, rd_valid=0, init_done=0, conflict_cnt=0.
  - Array contents are not reset directly; INIT zeroes them.
  - Reset asserted mid-operation aborts any accesses in flight and restarts INIT.
- FSM states:
  - INIT: each cycle writes 0 to word `ptr` in all banks in parallel, then ptr increments. After ptr = BANK_DEPTH-1 (BANK_DEPTH = 2^ADDR_W / NUM_BANKS) the FSM goes to RUN. INIT takes exactly BANK_DEPTH cycles and ignores CEB.
  - RUN: init_done=1. The FSM stays in RUN until reset.
- During INIT: rd_ready=0; wr_en and rd_en are ignored and dropped, with no side effects.
- Write accept (RUN): wr_en & !CEB. Data is written at the rising edge; the write always wins.
- rd_ready (combinational) = RUN & !CEB & !(wr_en & bank(wr_addr)==bank(rd_addr)).
- Read accept: rd_en & rd_ready at edge N → dout = mem[rd_addr] and rd_valid=1 after edge N+1. Latency is 1 cycle.
- Blocked read: the requester must hold rd_en and rd_addr stable until rd_ready.
- Same address, same cycle: cannot occur. The same-bank rule blocks the read; the read accepted next cycle returns the new data.
- Different banks, same cycle: both operations complete in that cycle.
- rd_valid=0 in any cycle following no accepted read. dout holds its last value.
- conflict_cnt increments on each cycle with rd_en & RUN & !CEB & !rd_ready. It saturates at all-ones with no wrap.
- CEB high in RUN: no accepts, rd_ready=0, conflict_cnt unchanged.

Decomposition:
- Package memory_bank_pkg holds:
  - the BANK_BITS = log2(NUM_BANKS) function;
  - the BANK_DEPTH calculation;
  - the FSM state encoding (INIT, RUN).
- Sub-module memory_bank_sp is one synchronous single-port bank:
  - ports: clk, en, we, addr, wdata, rdata;
  - 1-cycle registered read, no reset on the array.
- Top level instantiates NUM_BANKS copies with a generate loop. It contains the port muxing, arbitration, init FSM, output register and counter.

Test Plan (defaults):
1. Reset, then release → init_done=0 and rd_ready=0 for 1024 cycles, then init_done=1. A read of 0xDAC returns 0x00 with rd_valid one cycle later.
2. Write 0x0A@0x1F4, 0x0B@0x4B0, 0x0C@0xA8C, 0x0D@0xDAC (banks 0-3), then read each → dout 0x0A/0x0B/0x0C/0x0D, each with rd_valid one cycle after its accept.
3. Same cycle, write 0x0E@0x4B0 and read 0xA8C (banks 1/2) → rd_ready=1. Next cycle dout=0x0C; a later read of 0x4B0 returns 0x0E. conflict_cnt unchanged.
4. Same cycle, write 0x88@0xC80 and read 0xD48 (both bank 3), held for 3 cycles → rd_ready=0 and conflict_cnt=3. Drop wr_en → read accepted and returns old 0xD48 data. Repeat with rd_addr=0xC80 → returns 0x88.
5. CEB=1 with wr_en=1 to 0x12C (din=0x55) and rd_en=1 → no write, rd_ready=0, rd_valid stays 0. With CEB=0, a read of 0x12C returns the prior value.
6. Assert RESET during active writes → outputs clear asynchronously and INIT reruns. After init_done, reads of 0x1F4 and 0x4B0 return 0x00.
